// File: rtl/contador_bcd_mux_if.sv
// Bus bundle for contador_bcd_mux: count controls, BCD value and the muxed display drive.
interface contador_bcd_mux_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;

  modport master (
    output en, up, load, din,
    input  count, tc, an, seg
  );

  modport slave (
    input  en, up, load, din,
    output count, tc, an, seg
  );
endinterface

// File: rtl/contador_bcd_mux.sv
// Multi-digit up/down BCD counter with a time-multiplexed, active-low 7-segment scan driver.
// Define CONTADOR_BCD_MUX_LZB_EN to blank leading zeros on the display.
module contador_bcd_mux #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic               clk,
  input logic               rst,
  contador_bcd_mux_if.slave bus
);

  localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned ScanW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [RefW-1:0]  RefLast  = RefW'(REFRESH_DIV - 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(DIGITS - 1);
  localparam logic [6:0]       SegBlank = 7'b1111111;

  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0000100;
      default: pat = SegBlank;
    endcase
    return pat;
  endfunction

  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] load_val, inc_val, dec_val;
  logic                carry, borrow;
  logic                all_nine, all_zero;

  logic [RefW-1:0]     ref_q, ref_d;
  logic [ScanW-1:0]    scan_q, scan_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          cur_digit;
  logic                blank;

  // Ripple carry/borrow across digits; the final carry/borrow doubles as the all-9s/all-0s flag.
  always_comb begin
    inc_val  = '0;
    dec_val  = '0;
    load_val = '0;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        inc_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
      end else begin
        inc_val[4*i +: 4] = count_q[4*i +: 4];
      end
      carry = carry & (count_q[4*i +: 4] == 4'd9);

      if (borrow) begin
        dec_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1;
      end else begin
        dec_val[4*i +: 4] = count_q[4*i +: 4];
      end
      borrow = borrow & (count_q[4*i +: 4] == 4'd0);

      // Non-decimal codes are sanitised so count_q only ever holds valid BCD.
      load_val[4*i +: 4] = (bus.din[4*i +: 4] > 4'd9) ? 4'd0 : bus.din[4*i +: 4];
    end
    all_nine = carry;
    all_zero = borrow;
  end

  always_comb begin
    count_d = count_q;
    if (bus.load) begin
      count_d = load_val;
    end else if (bus.en) begin
      count_d = bus.up ? inc_val : dec_val;
    end
  end

  always_comb begin
    ref_d  = ref_q + RefW'(1);
    scan_d = scan_q;
    if (ref_q == RefLast) begin
      ref_d  = '0;
      scan_d = (scan_q == ScanLast) ? '0 : scan_q + ScanW'(1);
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    an_d      = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (ScanW'(i) == scan_q) begin
        cur_digit = count_q[4*i +: 4];
        an_d[i]   = 1'b0;
      end
    end
  end

`ifdef CONTADOR_BCD_MUX_LZB_EN
  // Walk from the most significant digit down; a digit is a leading zero while every digit
  // at or above it is zero. Digit 0 is never blanked.
  logic lead_zero;
  always_comb begin
    lead_zero = 1'b1;
    blank     = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      lead_zero = lead_zero & (count_q[4*i +: 4] == 4'd0);
      if ((ScanW'(i) == scan_q) && (i != 0)) begin
        blank = lead_zero;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_d = blank ? SegBlank : seg_pattern(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ref_q   <= '0;
      scan_q  <= '0;
      an_q    <= '1;
      seg_q   <= SegBlank;
    end else begin
      count_q <= count_d;
      ref_q   <= ref_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = bus.en & ~bus.load & (bus.up ? all_nine : all_zero);
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;

endmodule

// File: tb/tb_contador_bcd_mux.sv
// Directed self-checking bench for contador_bcd_mux with DIGITS=2, REFRESH_DIV=4.
module tb_contador_bcd_mux;

  localparam int unsigned DIGITS      = 2;
  localparam int unsigned REFRESH_DIV = 4;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] SB = 7'b1111111;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  contador_bcd_mux_if #(.DIGITS(DIGITS)) bus ();

  contador_bcd_mux #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en   = 1'b0;
    bus.up   = 1'b0;
    bus.load = 1'b0;
    bus.din  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.count !== 8'h00) begin
      n_errors++; $display("FAIL reset_count: got %h expected 00", bus.count);
    end
    n_checks++;
    if (bus.an !== 2'b11) begin
      n_errors++; $display("FAIL reset_an: got %b expected 11", bus.an);
    end
    n_checks++;
    if (bus.seg !== SB) begin
      n_errors++; $display("FAIL reset_seg: got %b expected %b", bus.seg, SB);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.an !== 2'b10) begin
      n_errors++; $display("FAIL post_reset_an: got %b expected 10", bus.an);
    end
    n_checks++;
    if (bus.seg !== S0) begin
      n_errors++; $display("FAIL post_reset_seg: got %b expected %b", bus.seg, S0);
    end
  endtask

  task automatic test_load_inc();
    bus.load = 1'b1;
    bus.din  = 8'h98;
    tick();
    bus.load = 1'b0;
    n_checks++;
    if (bus.count !== 8'h98) begin
      n_errors++; $display("FAIL load_98: got %h expected 98", bus.count);
    end
    bus.en = 1'b1;
    bus.up = 1'b1;
    #1;
    n_checks++;
    if (bus.tc !== 1'b0) begin
      n_errors++; $display("FAIL tc_at_98: got %b expected 0", bus.tc);
    end
    tick();
    n_checks++;
    if (bus.count !== 8'h99) begin
      n_errors++; $display("FAIL inc_99: got %h expected 99", bus.count);
    end
    n_checks++;
    if (bus.tc !== 1'b1) begin
      n_errors++; $display("FAIL tc_at_99: got %b expected 1", bus.tc);
    end
    // load suppresses tc even at all-9s
    bus.load = 1'b1;
    bus.din  = 8'h99;
    #1;
    n_checks++;
    if (bus.tc !== 1'b0) begin
      n_errors++; $display("FAIL tc_load_mask: got %b expected 0", bus.tc);
    end
    bus.load = 1'b0;
    #1;
    tick();
    n_checks++;
    if (bus.count !== 8'h00) begin
      n_errors++; $display("FAIL inc_wrap: got %h expected 00", bus.count);
    end
    n_checks++;
    if (bus.tc !== 1'b0) begin
      n_errors++; $display("FAIL tc_after_wrap: got %b expected 0", bus.tc);
    end
    idle_inputs();
  endtask

  task automatic test_dec_load_sanitise();
    bus.en = 1'b1;
    bus.up = 1'b0;
    #1;
    n_checks++;
    if (bus.tc !== 1'b1) begin
      n_errors++; $display("FAIL tc_dec_at_00: got %b expected 1", bus.tc);
    end
    tick();
    n_checks++;
    if (bus.count !== 8'h99) begin
      n_errors++; $display("FAIL dec_wrap: got %h expected 99", bus.count);
    end
    n_checks++;
    if (bus.tc !== 1'b0) begin
      n_errors++; $display("FAIL tc_dec_at_99: got %b expected 0", bus.tc);
    end
    tick();
    n_checks++;
    if (bus.count !== 8'h98) begin
      n_errors++; $display("FAIL dec_98: got %h expected 98", bus.count);
    end
    idle_inputs();
    bus.load = 1'b1;
    bus.din  = 8'h3F;
    tick();
    bus.load = 1'b0;
    n_checks++;
    if (bus.count !== 8'h30) begin
      n_errors++; $display("FAIL load_sanitise: got %h expected 30", bus.count);
    end
    tick();
    n_checks++;
    if (bus.count !== 8'h30) begin
      n_errors++; $display("FAIL hold: got %h expected 30", bus.count);
    end
  endtask

  task automatic test_priority();
    bus.load = 1'b1;
    bus.en   = 1'b1;
    bus.up   = 1'b1;
    bus.din  = 8'h05;
    tick();
    n_checks++;
    if (bus.count !== 8'h05) begin
      n_errors++; $display("FAIL load_over_en: got %h expected 05", bus.count);
    end
    bus.din = 8'h77;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus.count !== 8'h00) begin
      n_errors++; $display("FAIL rst_over_load: got %h expected 00", bus.count);
    end
    idle_inputs();
  endtask

  // Reset to align the scan, then load value at edge 1; after edge k the displayed scan
  // index is ((k-1)/4) % 2 and from edge 2 on the digits shown are those of value.
  task automatic run_scan(input logic [7:0] value, input logic [6:0] seg_hi,
                          input logic [6:0] seg_lo, input int cycles);
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.load = 1'b1;
    bus.din  = value;
    tick();
    bus.load = 1'b0;
    for (int k = 2; k < 2 + cycles; k++) begin
      bus.up = k[0];
      tick();
      exp_an  = (((k - 1) / 4) % 2 == 1) ? 2'b01 : 2'b10;
      exp_seg = (exp_an == 2'b01) ? seg_hi : seg_lo;
      n_checks++;
      if (bus.an !== exp_an) begin
        n_errors++; $display("FAIL scan_an k=%0d: got %b expected %b", k, bus.an, exp_an);
      end
      n_checks++;
      if (bus.seg !== exp_seg) begin
        n_errors++; $display("FAIL scan_seg k=%0d: got %b expected %b", k, bus.seg, exp_seg);
      end
    end
    n_checks++;
    if (bus.count !== value) begin
      n_errors++; $display("FAIL scan_hold: got %h expected %h", bus.count, value);
    end
    idle_inputs();
  endtask

  task automatic test_scan();
    run_scan(8'h47, S4, S7, 16);
  endtask

  task automatic test_leading_zero();
`ifdef CONTADOR_BCD_MUX_LZB_EN
    run_scan(8'h07, SB, S7, 8);
    run_scan(8'h00, SB, S0, 8);
`else
    run_scan(8'h07, S0, S7, 8);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    idle_inputs();
    test_reset();
    test_load_inc();
    test_dec_load_sanitise();
    test_priority();
    test_scan();
    test_leading_zero();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
